// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller_pkg
// Brief    : Shared state encoding and default vector-table constants for
//            the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQUEST = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    localparam logic [31:0] C_VECTOR_BASE   = 32'h0000_0000;
    localparam logic [31:0] C_VECTOR_STRIDE = 32'h0000_0002;

endpackage : interrupt_controller_pkg
`default_nettype wire

// File: rtl/interrupt_controller_priority_encoder_lsb.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_lsb
// Brief    : Combinational encoder; lowest set request index wins.
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_lsb #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    always_comb begin
        o_idx = '0;
        // Scan downwards so the lowest set bit is the final assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = i[ID_W-1:0];
            end
        end
    end

    assign o_valid = |i_req;

endmodule : priority_encoder_lsb
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Brief    : Latches IRQ rising edges, raises one prioritised request to the
//            CPU and blocks nesting until return-from-interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter int          ID_W          = 2,
    parameter logic [31:0] VECTOR_BASE   = C_VECTOR_BASE,
    parameter logic [31:0] VECTOR_STRIDE = C_VECTOR_STRIDE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_irq,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic               i_ack,
    input  logic               i_rti,
    output logic               o_interrupt,
    output logic [ID_W-1:0]    o_src_id,
    output logic [31:0]        o_vector,
    output logic [NUM_SRC-1:0] o_pending,
    output logic               o_in_service
);

    state_t             r_state;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic               r_interrupt;
    logic [ID_W-1:0]    r_src_id;
    logic               r_in_service;

    state_t             w_state_nxt;
    logic               w_interrupt_nxt;
    logic [ID_W-1:0]    w_src_id_nxt;
    logic               w_in_service_nxt;
    logic               w_ack_taken;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clear;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_eligible_vec;
    logic [ID_W-1:0]    w_winner;
    logic               w_eligible;

    assign w_rise         = i_irq & ~r_irq_prev;
    assign w_eligible_vec = r_pending & ~i_mask;

    priority_encoder_lsb #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .i_req   (w_eligible_vec),
        .o_idx   (w_winner),
        .o_valid (w_eligible)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_interrupt_nxt  = r_interrupt;
        w_src_id_nxt     = r_src_id;
        w_in_service_nxt = r_in_service;
        w_ack_taken      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible) begin
                    w_state_nxt     = ST_REQUEST;
                    w_src_id_nxt    = w_winner;
                    w_interrupt_nxt = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (i_ack) begin
                    w_ack_taken      = 1'b1;
                    w_state_nxt      = ST_SERVICE;
                    w_interrupt_nxt  = 1'b0;
                    w_in_service_nxt = 1'b1;
                end else if (w_eligible) begin
                    // A higher-priority arrival may replace the offered id before ack.
                    w_src_id_nxt = w_winner;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_interrupt_nxt = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (i_rti) begin
                    w_state_nxt      = ST_IDLE;
                    w_in_service_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_interrupt_nxt  = 1'b0;
                w_in_service_nxt = 1'b0;
            end
        endcase
    end

    // Set is applied after clear so a coincident new event survives the ack.
    assign w_clear       = w_ack_taken ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_src_id) : '0;
    assign w_pending_nxt = (r_pending & ~w_clear) | w_rise;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_interrupt  <= 1'b0;
            r_src_id     <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_irq_prev   <= i_irq;
            r_pending    <= w_pending_nxt;
            r_interrupt  <= w_interrupt_nxt;
            r_src_id     <= w_src_id_nxt;
            r_in_service <= w_in_service_nxt;
        end
    end

    assign o_interrupt  = r_interrupt;
    assign o_src_id     = r_src_id;
    assign o_pending    = r_pending;
    assign o_in_service = r_in_service;
    assign o_vector     = VECTOR_BASE + 32'(r_src_id) * VECTOR_STRIDE;

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Brief    : Random and directed stimulus against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [N-1:0] irq, mask;
    logic         ack, rti;
    logic         dut_int;
    logic [1:0]   dut_id;
    logic [31:0]  dut_vec;
    logic [N-1:0] dut_pend;
    logic         dut_svc;

    int vectors = 0;
    int errors  = 0;
    bit checking = 1'b0;

    // Model state: plain per-source flags and a mode name.
    bit    m_pend [N];
    bit    m_prev [N];
    string m_mode = "idle";
    int    m_id   = 0;

    interrupt_controller #(
        .NUM_SRC       (4),
        .ID_W          (2),
        .VECTOR_BASE   (32'h0000_0000),
        .VECTOR_STRIDE (32'h0000_0002)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_in),
        .i_irq        (irq),
        .i_mask       (mask),
        .i_ack        (ack),
        .i_rti        (rti),
        .o_interrupt  (dut_int),
        .o_src_id     (dut_id),
        .o_vector     (dut_vec),
        .o_pending    (dut_pend),
        .o_in_service (dut_svc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Reference model: follows the behavioural rules on each rising edge.
    always @(posedge clk) begin
        bit rise [N];
        int win;
        if (rst_in) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 0; end
            m_mode = "idle";
            m_id   = 0;
        end else begin
            bit took;
            foreach (rise[i]) begin
                rise[i]   = irq[i] && !m_prev[i];
                m_prev[i] = irq[i];
            end
            win = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && !mask[i]) win = i;
            took = 0;
            if (m_mode == "idle") begin
                if (win >= 0) begin m_mode = "request"; m_id = win; end
            end else if (m_mode == "request") begin
                if (ack) begin m_mode = "service"; took = 1; end
                else if (win >= 0) m_id = win;
                else m_mode = "idle";
            end else if (rti) begin
                m_mode = "idle";
            end
            if (took) m_pend[m_id] = 0;
            foreach (rise[i]) if (rise[i]) m_pend[i] = 1;
        end
    end

    // Compare every cycle on the falling edge, once reset has been applied.
    always @(negedge clk) begin
        if (checking) begin
            chk("interrupt",  {31'd0, dut_int}, {31'd0, m_mode == "request"});
            chk("src_id",     {30'd0, dut_id},  32'(m_id));
            chk("vector",     dut_vec,          32'(m_id) * 32'd2);
            chk("pending",    {28'd0, dut_pend}, {28'd0, model_pend_vec()});
            chk("in_service", {31'd0, dut_svc}, {31'd0, m_mode == "service"});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        ack = 1; step(); ack = 0;
    endtask

    task automatic pulse_rti();
        rti = 1; step(); rti = 0;
    endtask

    initial begin
        int rises;
        logic prev_int;
        rst_in = 1; irq = '0; mask = '0; ack = 0; rti = 0;
        step(2);
        checking = 1;
        chk("reset_int", {31'd0, dut_int}, 32'd0);
        chk("reset_pend", {28'd0, dut_pend}, 32'd0);
        rst_in = 0;

        // Basic request / ack / rti.
        irq = 4'b0100; step();
        chk("lit_pend_0100", {28'd0, dut_pend}, 32'h4);
        chk("lit_int_early", {31'd0, dut_int}, 32'd0);
        step();
        chk("lit_int_set", {31'd0, dut_int}, 32'd1);
        chk("lit_id_2", {30'd0, dut_id}, 32'd2);
        chk("lit_vec_4", dut_vec, 32'h4);
        pulse_ack();
        chk("lit_svc", {31'd0, dut_svc}, 32'd1);
        chk("lit_pend_clr", {28'd0, dut_pend}, 32'd0);
        pulse_rti();
        chk("lit_idle_svc", {31'd0, dut_svc}, 32'd0);
        irq = '0; step();

        // Preemption before ack.
        irq = 4'b1000; step(2);
        chk("lit_id_3", {30'd0, dut_id}, 32'd3);
        irq = 4'b1001; step(2);
        chk("lit_preempt_id", {30'd0, dut_id}, 32'd0);
        chk("lit_preempt_int", {31'd0, dut_int}, 32'd1);
        pulse_ack();
        chk("lit_pend_1000", {28'd0, dut_pend}, 32'h8);
        pulse_rti(); step();
        chk("lit_next_id_3", {30'd0, dut_id}, 32'd3);
        chk("lit_next_int", {31'd0, dut_int}, 32'd1);
        ack = 1; rti = 1; step(); ack = 0; rti = 0;
        pulse_rti(); irq = '0; step(2);

        // Masked source.
        mask = 4'b0010; irq = 4'b0010; step(3);
        chk("lit_mask_pend", {28'd0, dut_pend}, 32'h2);
        chk("lit_mask_int", {31'd0, dut_int}, 32'd0);
        mask = '0; step();
        chk("lit_unmask_id", {30'd0, dut_id}, 32'd1);
        pulse_rti();              // stray rti in REQUEST
        pulse_ack(); pulse_rti(); irq = '0; step();
        pulse_ack();              // stray ack in IDLE

        // Held irq yields one service.
        irq = 4'b0001; rises = 0; prev_int = dut_int;
        for (int c = 0; c < 10; c++) begin
            ack = dut_int; rti = dut_svc; step();
            if (dut_int && !prev_int) rises++;
            prev_int = dut_int;
        end
        ack = 0; rti = 0;
        chk("lit_held_one", 32'(rises), 32'd1);

        // Reset during service.
        irq = 4'b0000; step(3);
        irq = 4'b0001; step(2); pulse_ack();
        irq = 4'b0111; step();
        chk("lit_svc_pend", {28'd0, dut_pend}, 32'h6);
        rst_in = 1; irq = '0; step(); rst_in = 0;
        chk("lit_rst_pend", {28'd0, dut_pend}, 32'd0);
        chk("lit_rst_svc", {31'd0, dut_svc}, 32'd0);
        step(4);
        chk("lit_rst_quiet", {31'd0, dut_int}, 32'd0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            ack    = ($urandom_range(0, 3) == 0);
            rti    = ($urandom_range(0, 4) == 0);
            rst_in = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_in = 0; ack = 0; rti = 0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_interrupt_controller
`default_nettype wire
